// File: rtl/regfile_mp.sv
// Multi-port architectural register file with write-to-read bypass
// and a valid/ready sequential dump port.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int R0_ZERO  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   idx_nx;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                wr_ok0;
    logic                wr_ok1;
    logic                r0_hard;
    logic [ADDR_W-1:0]   ra;

    assign r0_hard = (R0_ZERO != 0);

    // Writes to a hardwired r0 are dropped, so they must not bypass either.
    assign wr_ok0 = wr_en0 && !(r0_hard && wr_addr0 == '0);
    assign wr_ok1 = wr_en1 && !(r0_hard && wr_addr1 == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok1 && wr_addr1 == ADDR_W'(i)) begin
                    regs[i] <= wr_data1;
                end else if (wr_ok0 && wr_addr0 == ADDR_W'(i)) begin
                    regs[i] <= wr_data0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (r0_hard && ra == '0) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (wr_ok1 && wr_addr1 == ra) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data1;
            end else if (wr_ok0 && wr_addr0 == ra) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[ra];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        unique case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nx = DUMP;
                    idx_nx   = '0;
                end
            end
            DUMP: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                dump_addr  = idx;
                // Stored value only: the dump never sees same-cycle bypass.
                if (!(r0_hard && idx == '0)) begin
                    dump_data = regs[idx];
                end
                if (dump_ready) begin
                    if (idx == ADDR_W'(NUM_REGS - 1)) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an
// array-based model of the architectural register state.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int RD = 2;

    logic            clk;
    logic            rst_n;
    logic [RD*AW-1:0] rd_addr;
    logic [RD*DW-1:0] rd_data;
    logic            wr_en0;
    logic [AW-1:0]   wr_addr0;
    logic [DW-1:0]   wr_data0;
    logic            wr_en1;
    logic [AW-1:0]   wr_addr1;
    logic [DW-1:0]   wr_data1;
    logic            dump_start;
    logic            dump_busy;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_addr;
    logic [DW-1:0]   dump_data;
    logic            dump_done;

    int total;
    int bad;

    logic [DW-1:0] mdl [NR];
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];

    regfile_mp #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
        .NUM_RD(RD), .R0_ZERO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wr_en1 && wr_addr1 == a) return wr_data1;
        if (wr_en0 && wr_addr0 == a) return wr_data0;
        return mdl[a];
    endfunction

    task automatic clear_mdl();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
    endtask

    // Commit pending writes to the model, then advance to the next negedge.
    task automatic tick();
        if (rst_n) begin
            if (wr_en0 && wr_addr0 != 0) mdl[wr_addr0] = wr_data0;
            if (wr_en1 && wr_addr1 != 0) mdl[wr_addr1] = wr_data1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en0 = 0; wr_en1 = 0;
        wr_addr0 = '0; wr_addr1 = '0;
        wr_data0 = '0; wr_data1 = '0;
        dump_start = 0; dump_ready = 0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] r;
        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        tick();
        wr_en0 = 0;
        #1;
        total++;
        if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL pre_reset_r5 got=%h exp=%h",
                     rd_data[DW-1:0], 32'hDEADBEEF);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (rd_data[DW-1:0] !== '0) begin
            bad++;
            $display("FAIL reset_r5 got=%h exp=0", rd_data[DW-1:0]);
        end
        for (int i = 0; i < NR; i++) begin
            rd_addr = {AW'(NR - 1 - i), AW'(i)};
            #1;
            r = rd_data[DW-1:0];
            total++;
            if (r !== '0 || rd_data[2*DW-1:DW] !== '0) begin
                bad++;
                $display("FAIL reset_reg%0d got=%h/%h exp=0", i,
                         r, rd_data[2*DW-1:DW]);
            end
        end
        total++;
        if ({dump_busy, dump_valid, dump_done} !== 3'b000 ||
            dump_addr !== '0 || dump_data !== '0) begin
            bad++;
            $display("FAIL reset_dump got=%b%b%b a=%h d=%h exp=0",
                     dump_busy, dump_valid, dump_done,
                     dump_addr, dump_data);
        end
        clear_mdl();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        wr_en0 = 1; wr_addr0 = 7; wr_data0 = 32'h12345678;
        rd_addr = {5'd7, 5'd7};
        #1;
        total++;
        if (rd_data !== {2{32'h12345678}}) begin
            bad++;
            $display("FAIL bypass_r7 got=%h exp=%h",
                     rd_data, {2{32'h12345678}});
        end
        tick();
        wr_en0 = 0;
        #1;
        total++;
        if (rd_data !== {2{32'h12345678}}) begin
            bad++;
            $display("FAIL stored_r7 got=%h exp=%h",
                     rd_data, {2{32'h12345678}});
        end
    endtask

    task automatic test_priority();
        wr_en0 = 1; wr_addr0 = 3; wr_data0 = 32'h1111;
        wr_en1 = 1; wr_addr1 = 3; wr_data1 = 32'h2222;
        rd_addr = {5'd3, 5'd3};
        #1;
        total++;
        if (rd_data[DW-1:0] !== 32'h2222) begin
            bad++;
            $display("FAIL prio_bypass got=%h exp=2222", rd_data[DW-1:0]);
        end
        tick();
        wr_en1 = 0; wr_en0 = 0;
        #1;
        total++;
        if (rd_data[DW-1:0] !== 32'h2222) begin
            bad++;
            $display("FAIL prio_stored got=%h exp=2222", rd_data[DW-1:0]);
        end
        wr_en0 = 1; wr_addr0 = 0; wr_data0 = 32'hFFFF;
        rd_addr = {5'd0, 5'd0};
        #1;
        total++;
        if (rd_data !== '0) begin
            bad++;
            $display("FAIL r0_bypass got=%h exp=0", rd_data);
        end
        tick();
        wr_en0 = 0;
        #1;
        total++;
        if (rd_data !== '0) begin
            bad++;
            $display("FAIL r0_stored got=%h exp=0", rd_data);
        end
    endtask

    task automatic test_random_rw();
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        int            lim;
        for (int n = 0; n < 300; n++) begin
            lim = (n % 3 == 0) ? 3 : NR - 1;
            wr_en0   = 1'($urandom);
            wr_en1   = 1'($urandom);
            wr_addr0 = AW'($urandom_range(0, lim));
            wr_addr1 = AW'($urandom_range(0, lim));
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            a0 = AW'($urandom_range(0, lim));
            a1 = AW'($urandom_range(0, lim));
            rd_addr = {a1, a0};
            #1;
            total++;
            if (rd_data[DW-1:0] !== exp_rd(a0) ||
                rd_data[2*DW-1:DW] !== exp_rd(a1)) begin
                bad++;
                $display("FAIL rand_rd n=%0d got=%h exp=%h%h", n,
                         rd_data, exp_rd(a1), exp_rd(a0));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic preload();
        for (int n = 0; n < NR / 2; n++) begin
            wr_en0 = 1; wr_addr0 = AW'(2 * n);
            wr_data0 = 32'(2 * n + 32'h100);
            wr_en1 = 1; wr_addr1 = AW'(2 * n + 1);
            wr_data1 = 32'(2 * n + 1 + 32'h100);
            tick();
        end
        idle_inputs();
    endtask

    // Drives one dump and records accepted beats; checks are done by callers.
    task automatic collect_dump(input bit toggle, output int n_done,
                                output int done_cyc, output int hold_bad);
        logic          pv;
        logic          pr;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        q_addr.delete();
        q_data.delete();
        n_done = 0; done_cyc = -1; hold_bad = 0;
        pv = 0; pr = 0; pa = '0; pd = '0;
        dump_start = 1;
        tick();
        dump_start = 0;
        for (int c = 1; c <= 200; c++) begin
            dump_ready = toggle ? (c % 2 == 1) : 1'b1;
            dump_start = (c >= 5 && c <= 10);
            #1;
            if (pv && !pr && dump_valid &&
                (dump_addr !== pa || dump_data !== pd)) hold_bad++;
            if (dump_valid && dump_ready) begin
                q_addr.push_back(dump_addr);
                q_data.push_back(dump_data);
            end
            if (dump_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            pv = dump_valid; pr = dump_ready;
            pa = dump_addr;  pd = dump_data;
            tick();
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        dump_start = 0;
        dump_ready = 0;
    endtask

    task automatic test_dump_full();
        int nd, dc, hb;
        logic [DW-1:0] e;
        preload();
        collect_dump(1'b0, nd, dc, hb);
        total++;
        if (q_addr.size() != NR) begin
            bad++;
            $display("FAIL full_beats got=%0d exp=%0d", q_addr.size(), NR);
        end
        for (int i = 0; i < q_addr.size() && i < NR; i++) begin
            e = (i == 0) ? 32'h0 : 32'(i + 32'h100);
            total++;
            if (q_addr[i] !== AW'(i) || q_data[i] !== e) begin
                bad++;
                $display("FAIL full_beat%0d got=%h:%h exp=%h:%h", i,
                         q_addr[i], q_data[i], AW'(i), e);
            end
        end
        total++;
        if (dc != NR + 1 || nd != 1) begin
            bad++;
            $display("FAIL full_done got=cyc%0d/n%0d exp=cyc%0d/n1",
                     dc, nd, NR + 1);
        end
        total++;
        if (dump_busy !== 1'b0) begin
            bad++;
            $display("FAIL full_idle got=%b exp=0", dump_busy);
        end
    endtask

    task automatic test_dump_stall();
        int nd, dc, hb;
        collect_dump(1'b1, nd, dc, hb);
        total++;
        if (q_addr.size() != NR || hb != 0) begin
            bad++;
            $display("FAIL stall_beats got=%0d/hold%0d exp=%0d/hold0",
                     q_addr.size(), hb, NR);
        end
        for (int i = 0; i < q_addr.size() && i < NR; i++) begin
            total++;
            if (q_addr[i] !== AW'(i) || q_data[i] !== mdl[i]) begin
                bad++;
                $display("FAIL stall_beat%0d got=%h:%h exp=%h:%h", i,
                         q_addr[i], q_data[i], AW'(i), mdl[i]);
            end
        end
        total++;
        if (dc != 2 * NR || nd != 1) begin
            bad++;
            $display("FAIL stall_done got=cyc%0d/n%0d exp=cyc%0d/n1",
                     dc, nd, 2 * NR);
        end
    endtask

    task automatic test_dump_writes();
        bit wrote;
        bit reached;
        wrote = 0; reached = 0;
        dump_start = 1;
        tick();
        dump_start = 0;
        for (int c = 1; c <= 200; c++) begin
            dump_ready = 1;
            #1;
            if (!dump_valid) begin
                tick();
                continue;
            end
            if (dump_addr == 20) begin
                #2 rst_n = 0;
                #1;
                total++;
                if ({dump_busy, dump_valid, dump_done} !== 3'b000 ||
                    dump_addr !== '0) begin
                    bad++;
                    $display("FAIL abort got=%b%b%b a=%h exp=000 a=0",
                             dump_busy, dump_valid, dump_done, dump_addr);
                end
                clear_mdl();
                for (int k = 0; k < 4; k++) begin
                    tick();
                    #1;
                    total++;
                    if (dump_done !== 0 || dump_valid !== 0) begin
                        bad++;
                        $display("FAIL abort_done got=%b%b exp=00",
                                 dump_done, dump_valid);
                    end
                end
                rst_n = 1;
                tick();
                #1;
                total++;
                if (dump_busy !== 1'b0 || dump_done !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_idle got=%b%b exp=00",
                             dump_busy, dump_done);
                end
                reached = 1;
                break;
            end
            if (dump_addr == 4 && !wrote) begin
                total++;
                if (dump_data !== mdl[4]) begin
                    bad++;
                    $display("FAIL beat4_old got=%h exp=%h",
                             dump_data, mdl[4]);
                end
                dump_ready = 0;
                wr_en0 = 1; wr_addr0 = 10; wr_data0 = 32'hCAFE;
                wr_en1 = 1; wr_addr1 = 4;  wr_data1 = 32'hBEEF;
                tick();
                wr_en0 = 0; wr_en1 = 0;
                dump_ready = 1;
                #1;
                total++;
                if (dump_addr !== 5'd4 || dump_data !== 32'hBEEF) begin
                    bad++;
                    $display("FAIL beat4_new got=%h:%h exp=04:0000beef",
                             dump_addr, dump_data);
                end
                wrote = 1;
                tick();
                continue;
            end
            if (dump_addr == 10) begin
                total++;
                if (dump_data !== 32'hCAFE) begin
                    bad++;
                    $display("FAIL beat10 got=%h exp=0000cafe", dump_data);
                end
            end
            total++;
            if (dump_data !== mdl[dump_addr]) begin
                bad++;
                $display("FAIL wbeat%0d got=%h exp=%h", dump_addr,
                         dump_data, mdl[dump_addr]);
            end
            tick();
        end
        total++;
        if (!reached || !wrote) begin
            bad++;
            $display("FAIL dump_writes_timeout got=%b%b exp=11",
                     wrote, reached);
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 0;
        rd_addr = '0;
        idle_inputs();
        clear_mdl();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_priority();
        test_random_rw();
        test_dump_full();
        test_dump_stall();
        test_dump_writes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, clocked architectural register file for the decode stage.
- Provides NUM_RD combinational read ports with write-to-read bypass and two synchronous write ports with fixed priority.
- Optional hardwired zero register.
- Includes a handshaked sequential dump port, so the testbench can extract the register contents without file I/O inside the RTL.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (power of two, ≥2)
- ADDR_W, 5, register index width; must equal log2(NUM_REGS)
- NUM_RD, 2, number of read ports (1..4)
- R0_ZERO, 1, 1 = register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- wr_en0  in  1  write port 0 enable (writeback path)
- wr_addr0  in  ADDR_W  write port 0 index
- wr_data0  in  DATA_W  write port 0 data
- wr_en1  in  1  write port 1 enable (higher priority)
- wr_addr1  in  ADDR_W  write port 1 index
- wr_data1  in  DATA_W  write port 1 data
- dump_start  in  1  request a full register dump
- dump_busy  out  1  dump in progress (states DUMP or DONE)
- dump_valid  out  1  dump_addr/dump_data hold a valid beat
- dump_ready  in  1  consumer accepts the beat
- dump_addr  out  ADDR_W  index of the current beat
- dump_data  out  DATA_W  register contents for the current beat
- dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers are cleared to 0.
  - The FSM goes to IDLE and the dump index to 0.
  - dump_busy, dump_valid and dump_done are 0; dump_addr and dump_data are 0.
  - Reset asserted mid-dump aborts the dump; no dump_done is produced.
- Writes:
  - Each enabled write port updates registers[wr_addrN] on the rising clk edge.
  - Both ports enabled with the same address: port 1 wins and port 0 is dropped.
  - With R0_ZERO=1, writes to address 0 are discarded.
- Reads (combinational, zero latency):
  - rd_data[k] = registers[rd_addr[k]], with bypass applied in the following priority order:
    1. R0_ZERO=1 and rd_addr[k]==0 → 0.
    2. wr_en1 and wr_addr1==rd_addr[k] → wr_data1.
    3. wr_en0 and wr_addr0==rd_addr[k] → wr_data0.
    4. Otherwise → stored value.
  - Bypass never applies to a discarded write to register 0.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: dump_start=1 → DUMP with idx=0. dump_start in any other state is ignored.
  - DUMP:
    - dump_valid=1, dump_addr=idx, dump_data=registers[idx]. This is the stored value, not bypassed; it reflects writes committed on earlier edges.
    - dump_addr and dump_data hold stable while dump_ready=0.
    - On dump_valid & dump_ready: if idx==NUM_REGS-1 → DONE, else idx+1.
    - With R0_ZERO=1, beat 0 carries 0.
  - DONE: dump_done=1 and dump_valid=0 for exactly one cycle, then → IDLE.
  - dump_busy=1 in DUMP and DONE.
- Writes remain fully functional during a dump.
  - A write to an index not yet dumped is reflected in its later beat.
  - A write to the index currently presented updates dump_data on the next cycle. The consumer samples on the accepting edge.
- A full dump with dump_ready held at 1 takes NUM_REGS cycles of valid, plus 1 DONE cycle.
- dump_addr and dump_data are 0 outside DUMP.

Test Plan:
1. Reset with rst_n=0 asynchronously mid-cycle, after writing 0xDEADBEEF to r5 → rd_data for r5 is 0 immediately; all registers read 0; dump_busy=0.
2. Write r7=0x12345678 via port 0; in the same cycle read r7 on ports 0 and 1 → both return 0x12345678 combinationally (bypass). After the edge, the stored value is 0x12345678.
3. Simultaneous wr_en0 r3=0x1111 and wr_en1 r3=0x2222 → bypass read gives 0x2222; after the edge r3=0x2222. With R0_ZERO=1, write r0=0xFFFF → r0 reads 0 in the same cycle and afterwards.
4. Preload rN=N+0x100 for all N; pulse dump_start with dump_ready=1 → 32 beats, dump_addr 0..31, data 0 (r0) then 0x101..0x11F; dump_done pulses once on cycle 33; dump_start during the dump is ignored.
5. Dump with dump_ready toggling 1/0 every cycle → each beat is held while ready=0; no beat is skipped or duplicated; 32 accepted beats.
6. During a dump at idx=4, write r10=0xCAFE and r4=0xBEEF → beat 10 reports 0xCAFE; beat 4 shows 0xBEEF from the next cycle. Assert rst_n=0 at idx=20 → FSM returns to IDLE, dump_valid=0, no dump_done.
